// File: rtl/instr_sequencer.sv
// Instruction sequencer: holds a small program buffer and replays it to a
// processor, inserting NOP bubbles after every issued word. Supports
// run-once, looping and single-step execution with an abort input.
module instr_sequencer #(
  parameter int              IW       = 32,
  parameter int              DEPTH    = 16,
  parameter int              NOP_GAP  = 4,
  parameter logic [IW-1:0]   NOP_WORD = '0,
  localparam int             AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  output logic          load_ready,
  input  logic          clear,
  input  logic [1:0]    mode,
  input  logic          start,
  input  logic          step,
  input  logic          stop,
  output logic [IW-1:0] Instruction,
  output logic          instr_valid,
  output logic [AW-1:0] issue_pc,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    GAP       = 2'b10,
    WAIT_STEP = 2'b11
  } state_t;

  localparam logic [1:0] MODE_ONCE = 2'b00;
  localparam logic [1:0] MODE_LOOP = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // Gap counter runs 0..NOP_GAP-1; one bit minimum keeps it legal when unused.
  localparam int             GW       = (NOP_GAP > 1) ? $clog2(NOP_GAP) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((NOP_GAP > 0) ? NOP_GAP - 1 : 0);
  localparam logic [AW:0]    CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]    CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
  localparam logic [GW-1:0]  GAP_ONE  = GW'(1);

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [1:0]      mode_q, mode_d;
  logic [AW:0]     count_q, count_d;
  logic            done_q, done_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            endOfGap;
  logic            lastWord;
  logic [IW-1:0]   mem_q [DEPTH];

  // The pointer sits on the final program word when it equals count-1.
  assign lastWord   = ({1'b0, ptr_q} == (count_q - CNT_ONE));
  assign load_ready = (state_q == IDLE) && (count_q < CNT_FULL) && !start && !clear;

  assign Instruction = instr_q;
  assign instr_valid = valid_q;
  assign issue_pc    = ptr_q;
  assign count       = count_q;
  assign busy        = busy_q;
  assign done        = done_q;

  // Program buffer write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (!reset && load_valid && load_ready) begin
      mem_q[count_q[AW-1:0]] <= load_data;
    end
  end

  // State and registered outputs, all forced to idle values by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gap_q   <= '0;
      mode_q  <= MODE_ONCE;
      count_q <= '0;
      done_q  <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      done_q  <= done_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic: loading/clear/start in IDLE, stop beats everything
  // while running, and the end of each bubble decides where to go next.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gap_d    = gap_q;
    mode_d   = mode_q;
    count_d  = count_q;
    done_d   = 1'b0;
    endOfGap = 1'b0;
    if (state_q == IDLE) begin
      if (clear) begin
        count_d = '0;
      end else if (start) begin
        if (count_q != '0) begin
          mode_d  = (mode == 2'b11) ? MODE_ONCE : mode;
          ptr_d   = '0;
          gap_d   = '0;
          state_d = ISSUE;
        end else begin
          done_d = 1'b1;
        end
      end else if (load_valid && load_ready) begin
        count_d = count_q + CNT_ONE;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ISSUE: begin
          if (NOP_GAP == 0) begin
            endOfGap = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            endOfGap = 1'b1;
          end else begin
            gap_d = gap_q + GAP_ONE;
          end
        end
        WAIT_STEP: begin
          if (step) begin
            if (lastWord) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ISSUE;
              ptr_d   = ptr_q + PTR_ONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (endOfGap) begin
        if (mode_q == MODE_STEP) begin
          state_d = WAIT_STEP;
        end else if (!lastWord) begin
          state_d = ISSUE;
          ptr_d   = ptr_q + PTR_ONE;
        end else if (mode_q == MODE_LOOP) begin
          state_d = ISSUE;
          ptr_d   = '0;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  // Output decode from the upcoming state so the registered word lines up
  // with the cycle the FSM spends in ISSUE.
  always_comb begin
    instr_d = NOP_WORD;
    valid_d = 1'b0;
    busy_d  = (state_d != IDLE);
    if (state_d == ISSUE) begin
      instr_d = mem_q[ptr_d];
      valid_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: scoreboard of per-cycle expected
// outputs, one task per scenario, plus a zero-gap instance.
module tb_instr_sequencer;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  typedef struct {
    logic [1:0]  mode;
    logic        start;
    logic        step;
    logic        stop;
    logic [31:0] instr;
    logic        valid;
    logic        done;
    logic        busy;
    logic [3:0]  pc;
  } cycle_t;

  logic        clk = 1'b0;
  logic        rst, loadValid, loadReady, clr, startIn, stepIn, stopIn;
  logic [31:0] loadData, instrOut;
  logic [1:0]  modeIn;
  logic        instrValid, busyOut, doneOut;
  logic [3:0]  issuePc;
  logic [4:0]  countOut;

  logic        zReset, zLoadValid, zLoadReady, zClear, zStart, zStep, zStop;
  logic [31:0] zLoadData, zInstr;
  logic [1:0]  zMode;
  logic        zValid, zBusy, zDone;
  logic [3:0]  zPc;
  logic [4:0]  zCount;

  cycle_t      expQ[$];
  logic [31:0] wordQ[$];
  int          nChecks = 0;
  int          nFails  = 0;

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  instr_sequencer #(.IW(32), .DEPTH(16), .NOP_GAP(4), .NOP_WORD(NOPW)) dut (
    .clk(clk), .reset(rst), .load_valid(loadValid), .load_data(loadData),
    .load_ready(loadReady), .clear(clr), .mode(modeIn), .start(startIn),
    .step(stepIn), .stop(stopIn), .Instruction(instrOut),
    .instr_valid(instrValid), .issue_pc(issuePc), .count(countOut),
    .busy(busyOut), .done(doneOut)
  );

  instr_sequencer #(.IW(32), .DEPTH(16), .NOP_GAP(0)) dut0 (
    .clk(clk), .reset(zReset), .load_valid(zLoadValid), .load_data(zLoadData),
    .load_ready(zLoadReady), .clear(zClear), .mode(zMode), .start(zStart),
    .step(zStep), .stop(zStop), .Instruction(zInstr),
    .instr_valid(zValid), .issue_pc(zPc), .count(zCount),
    .busy(zBusy), .done(zDone)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushCycle(input logic [1:0] m, input logic s, input logic st,
                           input logic sp, input logic [31:0] ins, input logic v,
                           input logic d, input logic b, input logic [3:0] p);
    cycle_t c;
    c.mode = m; c.start = s; c.step = st; c.stop = sp;
    c.instr = ins; c.valid = v; c.done = d; c.busy = b; c.pc = p;
    expQ.push_back(c);
  endtask

  task automatic applyStimulus(input logic [31:0] w);
    loadValid = 1'b1;
    loadData  = w;
    tick();
    loadValid = 1'b0;
  endtask

  task automatic clearProgram();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; zReset = 1'b1;
    tick(); tick();
    rst = 1'b0; zReset = 1'b0;
    #1;
    nChecks++; if (instrOut !== NOPW) begin nFails++; $display("[TB] FAIL reset_instr got %h want %h", instrOut, NOPW); end
    nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid got %b want 0", instrValid); end
    nChecks++; if (busyOut !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busyOut); end
    nChecks++; if (doneOut !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", doneOut); end
    nChecks++; if (countOut !== 5'd0) begin nFails++; $display("[TB] FAIL reset_count got %0d want 0", countOut); end
    nChecks++; if (issuePc !== 4'd0) begin nFails++; $display("[TB] FAIL reset_pc got %0d want 0", issuePc); end
    nChecks++; if (loadReady !== 1'b1) begin nFails++; $display("[TB] FAIL reset_load_ready got %b want 1", loadReady); end
    nChecks++; if (zInstr !== 32'h0) begin nFails++; $display("[TB] FAIL reset_z_instr got %h want 0", zInstr); end
  endtask

  task automatic test_run_once();
    cycle_t      e;
    logic [31:0] w [3];
    int          cyc = 0;
    w[0] = 32'hA000_0001; w[1] = 32'hB000_0002; w[2] = 32'hC000_0003;
    for (int i = 0; i < 3; i++) begin
      loadValid = 1'b1; loadData = w[i]; #1;
      nChecks++; if (loadReady !== 1'b1) begin nFails++; $display("[TB] FAIL load_ready_%0d got %b want 1", i, loadReady); end
      tick();
      loadValid = 1'b0;
    end
    nChecks++; if (countOut !== 5'd3) begin nFails++; $display("[TB] FAIL count_after_load got %0d want 3", countOut); end
    // mode 11 must behave as run-once
    for (int i = 0; i < 3; i++) begin
      pushCycle((i == 0) ? 2'b11 : 2'b00, i == 0, 1'b0, 1'b0, w[i], 1'b1, 1'b0, 1'b1, 4'(i));
      repeat (4) pushCycle(2'b00, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b1, 4'(i));
    end
    pushCycle(2'b00, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b1, 1'b0, 4'd2);
    pushCycle(2'b00, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b0, 4'd2);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      modeIn = e.mode; startIn = e.start; stepIn = e.step; stopIn = e.stop;
      tick();
      startIn = 1'b0; stepIn = 1'b0; stopIn = 1'b0;
      cyc++;
      nChecks++;
      if ({instrOut, instrValid, doneOut, busyOut, issuePc} !== {e.instr, e.valid, e.done, e.busy, e.pc}) begin
        nFails++;
        $display("[TB] FAIL run_once cycle %0d got instr=%h valid=%b done=%b busy=%b pc=%0d want instr=%h valid=%b done=%b busy=%b pc=%0d",
                 cyc, instrOut, instrValid, doneOut, busyOut, issuePc, e.instr, e.valid, e.done, e.busy, e.pc);
      end
    end
    nChecks++; if (countOut !== 5'd3) begin nFails++; $display("[TB] FAIL count_after_run got %0d want 3", countOut); end
  endtask

  task automatic test_empty_start();
    cycle_t e;
    int     cyc = 0;
    clr = 1'b1; loadValid = 1'b1; loadData = 32'h1234_5678; #1;
    nChecks++; if (loadReady !== 1'b0) begin nFails++; $display("[TB] FAIL clear_blocks_load got %b want 0", loadReady); end
    tick();
    clr = 1'b0; loadValid = 1'b0;
    nChecks++; if (countOut !== 5'd0) begin nFails++; $display("[TB] FAIL clear_count got %0d want 0", countOut); end
    pushCycle(2'b00, 1'b1, 1'b0, 1'b0, NOPW, 1'b0, 1'b1, 1'b0, 4'd2);
    pushCycle(2'b00, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b0, 4'd2);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      modeIn = e.mode; startIn = e.start; stepIn = e.step; stopIn = e.stop;
      tick();
      startIn = 1'b0; stepIn = 1'b0; stopIn = 1'b0;
      cyc++;
      nChecks++;
      if ({instrOut, instrValid, doneOut, busyOut, issuePc} !== {e.instr, e.valid, e.done, e.busy, e.pc}) begin
        nFails++;
        $display("[TB] FAIL empty_start cycle %0d got instr=%h valid=%b done=%b busy=%b pc=%0d want instr=%h valid=%b done=%b busy=%b pc=%0d",
                 cyc, instrOut, instrValid, doneOut, busyOut, issuePc, e.instr, e.valid, e.done, e.busy, e.pc);
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] expW;
    int          cyc = 0;
    logic        finished = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wordQ.push_back(32'hF000_0000 + 32'(i));
      applyStimulus(32'hF000_0000 + 32'(i));
    end
    nChecks++; if (countOut !== 5'd16) begin nFails++; $display("[TB] FAIL full_count got %0d want 16", countOut); end
    loadValid = 1'b1; loadData = 32'hBAD0_BAD0; #1;
    nChecks++; if (loadReady !== 1'b0) begin nFails++; $display("[TB] FAIL full_load_ready got %b want 0", loadReady); end
    tick();
    loadValid = 1'b0;
    nChecks++; if (countOut !== 5'd16) begin nFails++; $display("[TB] FAIL full_count_after_17th got %0d want 16", countOut); end
    modeIn = 2'b00; startIn = 1'b1;
    while (!finished && cyc < 200) begin
      tick();
      startIn = 1'b0;
      cyc++;
      if (instrValid === 1'b1) begin
        nChecks++;
        if (wordQ.size() == 0) begin
          nFails++; $display("[TB] FAIL full_extra_word got %h want none", instrOut);
        end else begin
          expW = wordQ.pop_front();
          if (instrOut !== expW) begin nFails++; $display("[TB] FAIL full_word got %h want %h", instrOut, expW); end
        end
      end
      if (doneOut === 1'b1) finished = 1'b1;
    end
    nChecks++; if (!finished) begin nFails++; $display("[TB] FAIL full_timeout got no done want done within 200 cycles"); end
    nChecks++; if (cyc != 81) begin nFails++; $display("[TB] FAIL full_done_cycle got %0d want 81", cyc); end
    nChecks++; if (wordQ.size() != 0) begin nFails++; $display("[TB] FAIL full_missing_words got %0d left want 0", wordQ.size()); end
  endtask

  task automatic test_loop();
    cycle_t      e;
    int          cyc = 0;
    int          pos;
    logic [31:0] a, b, ins;
    a = 32'h1111_AAAA; b = 32'h2222_BBBB;
    clearProgram();
    applyStimulus(a);
    applyStimulus(b);
    for (int k = 1; k <= 30; k++) begin
      pos = (k - 1) % 10;
      ins = (pos == 0) ? a : ((pos == 5) ? b : NOPW);
      // mode drops to run-once after start and must be ignored
      pushCycle((k == 1) ? 2'b01 : 2'b00, k == 1, 1'b0, 1'b0, ins, (pos == 0) || (pos == 5),
                1'b0, 1'b1, (pos < 5) ? 4'd0 : 4'd1);
    end
    // stop lands on the end of the gap and must win over the wrap
    pushCycle(2'b00, 1'b0, 1'b0, 1'b1, NOPW, 1'b0, 1'b0, 1'b0, 4'd1);
    pushCycle(2'b00, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b0, 4'd1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      modeIn = e.mode; startIn = e.start; stepIn = e.step; stopIn = e.stop;
      tick();
      startIn = 1'b0; stepIn = 1'b0; stopIn = 1'b0;
      cyc++;
      nChecks++;
      if ({instrOut, instrValid, doneOut, busyOut, issuePc} !== {e.instr, e.valid, e.done, e.busy, e.pc}) begin
        nFails++;
        $display("[TB] FAIL loop cycle %0d got instr=%h valid=%b done=%b busy=%b pc=%0d want instr=%h valid=%b done=%b busy=%b pc=%0d",
                 cyc, instrOut, instrValid, doneOut, busyOut, issuePc, e.instr, e.valid, e.done, e.busy, e.pc);
      end
    end
  endtask

  task automatic test_single_step();
    cycle_t      e;
    int          cyc = 0;
    logic [31:0] s0, s1;
    s0 = 32'h5EE0_0000; s1 = 32'h5EE0_0001;
    clearProgram();
    applyStimulus(s0);
    applyStimulus(s1);
    pushCycle(2'b10, 1'b1, 1'b0, 1'b0, s0, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int k = 2; k <= 5; k++)
      pushCycle(2'b10, 1'b0, k == 3, 1'b0, NOPW, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int k = 6; k <= 12; k++)
      pushCycle(2'b10, 1'b0, k == 6, 1'b0, NOPW, 1'b0, 1'b0, 1'b1, 4'd0);
    pushCycle(2'b10, 1'b0, 1'b1, 1'b0, s1, 1'b1, 1'b0, 1'b1, 4'd1);
    for (int k = 14; k <= 20; k++)
      pushCycle(2'b10, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b1, 4'd1);
    pushCycle(2'b10, 1'b0, 1'b1, 1'b0, NOPW, 1'b0, 1'b1, 1'b0, 4'd1);
    pushCycle(2'b10, 1'b0, 1'b0, 1'b0, NOPW, 1'b0, 1'b0, 1'b0, 4'd1);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      modeIn = e.mode; startIn = e.start; stepIn = e.step; stopIn = e.stop;
      tick();
      startIn = 1'b0; stepIn = 1'b0; stopIn = 1'b0;
      cyc++;
      nChecks++;
      if ({instrOut, instrValid, doneOut, busyOut, issuePc} !== {e.instr, e.valid, e.done, e.busy, e.pc}) begin
        nFails++;
        $display("[TB] FAIL single_step cycle %0d got instr=%h valid=%b done=%b busy=%b pc=%0d want instr=%h valid=%b done=%b busy=%b pc=%0d",
                 cyc, instrOut, instrValid, doneOut, busyOut, issuePc, e.instr, e.valid, e.done, e.busy, e.pc);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    clearProgram();
    applyStimulus(32'h7777_0000);
    applyStimulus(32'h7777_0001);
    modeIn = 2'b00; startIn = 1'b1;
    tick();
    startIn = 1'b0;
    nChecks++; if (instrOut !== 32'h7777_0000) begin nFails++; $display("[TB] FAIL midreset_first got %h want 77770000", instrOut); end
    tick(); tick();
    nChecks++; if (busyOut !== 1'b1) begin nFails++; $display("[TB] FAIL midreset_in_gap got busy=%b want 1", busyOut); end
    rst = 1'b1; startIn = 1'b1;
    tick();
    rst = 1'b0; startIn = 1'b0;
    nChecks++; if (instrOut !== NOPW) begin nFails++; $display("[TB] FAIL midreset_instr got %h want %h", instrOut, NOPW); end
    nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_valid got %b want 0", instrValid); end
    nChecks++; if (busyOut !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_busy got %b want 0", busyOut); end
    nChecks++; if (doneOut !== 1'b0) begin nFails++; $display("[TB] FAIL midreset_done got %b want 0", doneOut); end
    nChecks++; if (countOut !== 5'd0) begin nFails++; $display("[TB] FAIL midreset_count got %0d want 0", countOut); end
    nChecks++; if (issuePc !== 4'd0) begin nFails++; $display("[TB] FAIL midreset_pc got %0d want 0", issuePc); end
    tick();
    nChecks++; if ({doneOut, busyOut} !== 2'b00) begin nFails++; $display("[TB] FAIL midreset_after got done/busy=%b want 00", {doneOut, busyOut}); end
  endtask

  task automatic test_no_gap();
    logic [31:0] expW;
    for (int i = 0; i < 4; i++) begin
      zLoadValid = 1'b1; zLoadData = 32'hD00D_0000 + 32'(i); #1;
      nChecks++; if (zLoadReady !== 1'b1) begin nFails++; $display("[TB] FAIL nogap_load_ready_%0d got %b want 1", i, zLoadReady); end
      wordQ.push_back(zLoadData);
      tick();
      zLoadValid = 1'b0;
    end
    zMode = 2'b00; zStart = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      zStart = 1'b0;
      nChecks++;
      if (k <= 4) begin
        expW = wordQ.pop_front();
        if ({zInstr, zValid, zDone, zBusy, zPc} !== {expW, 1'b1, 1'b0, 1'b1, 4'(k - 1)}) begin
          nFails++;
          $display("[TB] FAIL nogap cycle %0d got instr=%h valid=%b done=%b busy=%b pc=%0d want instr=%h valid=1 done=0 busy=1 pc=%0d",
                   k, zInstr, zValid, zDone, zBusy, zPc, expW, k - 1);
        end
      end else if ({zInstr, zValid, zDone, zBusy} !== {32'h0, 1'b0, 1'b1, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL nogap_done cycle %0d got instr=%h valid=%b done=%b busy=%b want instr=0 valid=0 done=1 busy=0",
                 k, zInstr, zValid, zDone, zBusy);
      end
    end
  endtask

  // Scenario sequencing.
  initial begin
    rst = 1'b1; loadValid = 1'b0; loadData = '0; clr = 1'b0; modeIn = 2'b00;
    startIn = 1'b0; stepIn = 1'b0; stopIn = 1'b0;
    zReset = 1'b1; zLoadValid = 1'b0; zLoadData = '0; zClear = 1'b0; zMode = 2'b00;
    zStart = 1'b0; zStep = 1'b0; zStop = 1'b0;
    test_reset();
    test_run_once();
    test_empty_start();
    test_full();
    test_loop();
    test_single_step();
    test_reset_mid_gap();
    test_no_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter IW, default 32, SHALL set the instruction width.
REQ-003 Parameter DEPTH, default 16, SHALL set the program buffer entries (power of two, >=2); AW = clog2(DEPTH).
REQ-004 Parameter NOP_GAP, default 4, SHALL set the bubble cycles after each issued instruction (0 allowed).
REQ-005 Parameter NOP_WORD, default 32'h0000_0000, SHALL set the bubble encoding.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 load_valid  in  1  program write request.
REQ-009 load_data  in  IW  instruction word to append.
REQ-010 load_ready  out  1  append accepted this cycle when high with load_valid.
REQ-011 clear  in  1  empties program buffer (IDLE only).
REQ-012 mode  in  2  00 run-once, 01 loop, 10 single-step, 11 treated as 00.
REQ-013 start  in  1  begin execution (IDLE only).
REQ-014 step  in  1  advance one instruction in single-step mode.
REQ-015 stop  in  1  abort execution.
REQ-016 Instruction  out  IW  word driven to processor, registered.
REQ-017 instr_valid  out  1  high when Instruction is a program word, low for bubble.
REQ-018 issue_pc  out  AW  buffer index of current/last issued word.
REQ-019 count  out  AW+1  program length held.
REQ-020 busy  out  1  high in any state but IDLE.
REQ-021 done  out  1  one-cycle pulse at normal completion.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, GAP, WAIT_STEP; all outputs registered.
REQ-023 load_ready SHALL equal (state==IDLE) && (count<DEPTH) && !start && !clear; accepted word written at index count, count+1.
REQ-024 Full buffer (count==DEPTH): load_ready low, load_valid ignored, contents unchanged.
REQ-025 clear in IDLE SHALL set count=0 next cycle; clear outside IDLE ignored; clear has priority over load_valid.
REQ-026 start in IDLE with count>0: latch mode, ptr=0, enter ISSUE; Instruction=buffer[0], instr_valid=1 in the cycle after start is sampled.
REQ-027 start in IDLE with count==0: stay IDLE, done pulses next cycle.
REQ-028 ISSUE lasts exactly one cycle; then GAP for NOP_GAP cycles with Instruction=NOP_WORD, instr_valid=0; NOP_GAP=0 skips GAP.
REQ-029 End of gap, ptr<count-1: run-once/loop -> ptr+1, ISSUE; single-step -> WAIT_STEP.
REQ-030 End of gap, ptr==count-1: run-once -> IDLE with done=1 for one cycle; loop -> ptr=0, ISSUE (wrap, no done); single-step -> WAIT_STEP.
REQ-031 WAIT_STEP: Instruction=NOP_WORD; step -> ISSUE of ptr+1; if ptr==count-1 step -> IDLE with done pulse.
REQ-032 mode changes after start SHALL have no effect until next start; step outside WAIT_STEP ignored.
REQ-033 stop in any non-IDLE state -> IDLE next cycle, Instruction=NOP_WORD, instr_valid=0, no done; word already on Instruction that cycle remains issued.
REQ-034 stop and step/end-of-gap in same cycle: stop wins.
REQ-035 issue_pc SHALL hold ptr of the last ISSUE through GAP/WAIT_STEP; Instruction stream repeats with period count*(1+NOP_GAP) in loop mode.

Reset
REQ-036 reset SHALL force IDLE, count=0, ptr=issue_pc=0, Instruction=NOP_WORD, instr_valid=0, busy=0, done=0; buffer contents not cleared.
REQ-037 reset mid-run SHALL abort with no done pulse and override all other inputs.

Verification
REQ-038 Load 3 words A,B,C, mode 00, start -> A,4 NOP,B,4 NOP,C,4 NOP, done pulse at cycle 16 after start; count=3.
REQ-039 Load 16 words, attempt 17th -> load_ready low, count=16, 17th not stored.
REQ-040 mode 01, 2 words, run 30 cycles -> A,B each every 10 cycles, no done; stop -> NOP next cycle, busy=0.
REQ-041 mode 10, 2 words -> A then NOP held until step; step -> B; step -> done, IDLE.
REQ-042 NOP_GAP=0 build, 4 words run-once -> 4 back-to-back instr_valid cycles, done in cycle 5.
REQ-043 reset asserted during GAP -> all outputs at reset values next cycle, count=0, no done.
